// File: rtl/led_bist_ctrl_if.sv
// Board-facing signal bundle of the LED/switch self-test controller.
// master = board/stimulus side, slave = led_bist_ctrl.
interface led_bist_ctrl_if #(
   parameter int N = 4
);
   logic [N-1:0] sw;
   logic [1:0]   mode;
   logic [N-1:0] led;
   logic         bist_active;
   logic         sweep_done;
   logic [7:0]   sweep_cnt;

   modport master (
      output sw, mode,
      input  led, bist_active, sweep_done, sweep_cnt
   );

   modport slave (
      input  sw, mode,
      output led, bist_active, sweep_done, sweep_cnt
   );
endinterface

// File: rtl/led_bist_ctrl.sv
// LED/switch self-test controller: shows a test pattern while all switches are off,
// passes synchronised switches through otherwise. Optional debounce: LED_BIST_DEBOUNCE_EN.
module led_bist_ctrl #(
   parameter int N         = 4,
   parameter int TICK_DIV  = 10,
   parameter int DB_CYCLES = 4
) (
   input  logic            clk,
   input  logic            rst,
   led_bist_ctrl_if.slave  bus
);

   localparam int IW = $clog2(2 * N + 2);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [0:0] {
      S_BIST = 1'b0,
      S_PASS = 1'b1
   } state_t;

   if (N < 2 || TICK_DIV < 1 || DB_CYCLES < 1) begin : g_param_check
      $error("led_bist_ctrl: illegal parameter set");
   end

   logic [N-1:0]  sync1_r;
   logic [N-1:0]  sw_s_r;
   logic [N-1:0]  sw_d_s;
   logic          any_on_s;
   logic [PW-1:0] pre_r;
   logic          tick_s;
   logic          to_bist_s;
   state_t        state_r;
   logic [N-1:0]  led_r;
   logic          bist_active_r;
   logic          sweep_done_r;
   logic [7:0]    sweep_cnt_r;
   logic [IW-1:0] idx_r;
   logic [1:0]    mode_q_r;
   logic          first_r;
   logic [1:0]    mode_eff_s;
   logic [N-1:0]  pat_s;
   logic          last_s;

   function automatic logic [N-1:0] checker_word(input logic odd);
      logic [N-1:0] w;
      for (int i = 0; i < N; i++) begin
         w[i] = ((i % 2) == 1) ? odd : ~odd;
      end
      return w;
   endfunction

   // Two-flop synchroniser for the asynchronous switch pins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r <= {N{1'b0}};
         sw_s_r  <= {N{1'b0}};
      end else begin
         sync1_r <= bus.sw;
         sw_s_r  <= sync1_r;
      end
   end

`ifdef LED_BIST_DEBOUNCE_EN
   localparam int CW = $clog2(DB_CYCLES + 1);

   logic [N-1:0]  prev_r;
   logic [N-1:0]  sw_deb_r;
   logic [CW-1:0] db_cnt_r;
   logic [CW-1:0] db_next_s;

   // Length of the current run of identical synchronised samples, saturating.
   always_comb begin
      db_next_s = db_cnt_r;
      if (sw_s_r != prev_r) begin
         db_next_s = CW'(1);
      end else if (db_cnt_r >= CW'(DB_CYCLES)) begin
         db_next_s = CW'(DB_CYCLES);
      end else begin
         db_next_s = db_cnt_r + CW'(1);
      end
   end

   // Debounced value follows sw_s only once it has been stable for the full window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_r   <= {N{1'b0}};
         sw_deb_r <= {N{1'b0}};
         db_cnt_r <= {CW{1'b0}};
      end else begin
         prev_r   <= sw_s_r;
         db_cnt_r <= db_next_s;
         if (db_next_s >= CW'(DB_CYCLES)) begin
            sw_deb_r <= sw_s_r;
         end else begin
            sw_deb_r <= sw_deb_r;
         end
      end
   end

   assign sw_d_s = sw_deb_r;
`else
   assign sw_d_s = sw_s_r;
`endif

   assign any_on_s   = |sw_d_s;
   assign tick_s     = (pre_r == PW'(TICK_DIV - 1));
   assign to_bist_s  = (state_r == S_PASS) && !any_on_s;
   assign mode_eff_s = first_r ? bus.mode : mode_q_r;

   // Pattern-step prescaler; restarts on self-test entry so the first step is a full period away.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_r <= {PW{1'b0}};
      end else if (to_bist_s || tick_s) begin
         pre_r <= {PW{1'b0}};
      end else begin
         pre_r <= pre_r + PW'(1);
      end
   end

   // Next LED value for the current step and whether that step closes the sweep.
   always_comb begin
      pat_s  = {N{1'b0}};
      last_s = 1'b0;
      case (mode_eff_s)
         2'b00: begin
            if (idx_r < IW'(N)) begin
               pat_s = {1'b1, led_r[N-1:1]};
            end else if (idx_r < IW'(2 * N)) begin
               pat_s = {led_r[N-2:0], 1'b0};
            end else begin
               pat_s  = {N{1'b0}};
               last_s = 1'b1;
            end
         end
         2'b01: begin
            if (idx_r < IW'(N)) begin
               pat_s = {{(N-1){1'b0}}, 1'b1} << idx_r;
            end else begin
               pat_s  = {N{1'b0}};
               last_s = 1'b1;
            end
         end
         2'b10: begin
            if (idx_r == IW'(0)) begin
               pat_s = {N{1'b1}};
            end else begin
               pat_s  = {N{1'b0}};
               last_s = 1'b1;
            end
         end
         2'b11: begin
            if (idx_r == IW'(0)) begin
               pat_s = checker_word(1'b0);
            end else begin
               pat_s  = checker_word(1'b1);
               last_s = 1'b1;
            end
         end
         default: begin
            pat_s  = {N{1'b0}};
            last_s = 1'b1;
         end
      endcase
   end

   // Self-test / pass-through FSM with all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= S_BIST;
         led_r         <= {N{1'b0}};
         bist_active_r <= 1'b1;
         sweep_done_r  <= 1'b0;
         sweep_cnt_r   <= 8'd0;
         idx_r         <= {IW{1'b0}};
         mode_q_r      <= 2'b00;
         first_r       <= 1'b1;
      end else begin
         sweep_done_r <= 1'b0;
         first_r      <= 1'b0;
         if (first_r) begin
            mode_q_r <= bus.mode;
         end
         case (state_r)
            S_BIST: begin
               // Pass-through takes priority over a coincident pattern tick.
               if (any_on_s) begin
                  state_r       <= S_PASS;
                  led_r         <= sw_d_s;
                  bist_active_r <= 1'b0;
               end else if (tick_s) begin
                  led_r <= pat_s;
                  if (last_s) begin
                     idx_r        <= {IW{1'b0}};
                     sweep_done_r <= 1'b1;
                     mode_q_r     <= bus.mode;
                     if (sweep_cnt_r != 8'd255) begin
                        sweep_cnt_r <= sweep_cnt_r + 8'd1;
                     end
                  end else begin
                     idx_r <= idx_r + IW'(1);
                  end
               end
            end
            S_PASS: begin
               led_r <= sw_d_s;
               if (!any_on_s) begin
                  state_r       <= S_BIST;
                  led_r         <= {N{1'b0}};
                  idx_r         <= {IW{1'b0}};
                  bist_active_r <= 1'b1;
                  mode_q_r      <= bus.mode;
               end
            end
            default: begin
               state_r       <= S_BIST;
               led_r         <= {N{1'b0}};
               idx_r         <= {IW{1'b0}};
               bist_active_r <= 1'b1;
            end
         endcase
      end
   end

   assign bus.led         = led_r;
   assign bus.bist_active = bist_active_r;
   assign bus.sweep_done  = sweep_done_r;
   assign bus.sweep_cnt   = sweep_cnt_r;

endmodule

// File: tb/tb_led_bist_ctrl.sv
// Self-checking bench for led_bist_ctrl: two instances (TICK_DIV 10 and 1) share stimulus
// and are compared every cycle against a step-level reference model plus directed checks.
module tb_led_bist_ctrl;

   localparam int NCH = 4;
   localparam int DB  = 4;
`ifdef LED_BIST_DEBOUNCE_EN
   localparam int EXTRA = DB;
   localparam bit DEB   = 1'b1;
`else
   localparam int EXTRA = 0;
   localparam bit DEB   = 1'b0;
`endif
   localparam int LAT = 3 + EXTRA;

   typedef struct packed {
      bit         bist;
      logic [3:0] led;
      int         step;
      logic [1:0] modeq;
      int         phase;
      bit         done;
      int         cnt;
      bit         first;
   } mdl_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   led_bist_ctrl_if #(.N(NCH)) ifa ();
   led_bist_ctrl_if #(.N(NCH)) ifb ();

   led_bist_ctrl #(.N(NCH), .TICK_DIV(10), .DB_CYCLES(DB)) dut_a (
      .clk(clk), .rst(rst), .bus(ifa)
   );
   led_bist_ctrl #(.N(NCH), .TICK_DIV(1), .DB_CYCLES(DB)) dut_b (
      .clk(clk), .rst(rst), .bus(ifb)
   );

   int         checks = 0;
   int         errors = 0;
   mdl_t       ma, mb;
   logic [3:0] swq[$];
   logic [3:0] ssq[$];
   logic [3:0] deb;
   logic [3:0] sw_v;
   logic [1:0] mode_v;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic mdl_t m_reset();
      mdl_t r;
      r.bist = 1'b1; r.led = 4'b0000; r.step = 0; r.modeq = 2'b00;
      r.phase = 0; r.done = 1'b0; r.cnt = 0; r.first = 1'b1;
      return r;
   endfunction

   // One clock edge of the behaviour: swd is the (synchronised/debounced) switch word.
   function automatic mdl_t m_edge(mdl_t m, logic [3:0] swd, logic [1:0] md, int td);
      mdl_t       r;
      int         len;
      logic [1:0] me;
      r = m;
      r.done  = 1'b0;
      r.phase = m.phase + 1;
      me = m.first ? md : m.modeq;
      if (m.first) begin
         r.modeq = md;
         r.first = 1'b0;
      end
      if (m.bist) begin
         if (swd != 4'b0000) begin
            r.bist = 1'b0;
            r.led  = swd;
         end else if ((m.phase % td) == td - 1) begin
            case (me)
               2'b00:   len = 2 * NCH + 1;
               2'b01:   len = NCH + 1;
               default: len = 2;
            endcase
            case (me)
               2'b00: r.led = (m.step < NCH) ? (4'b1000 | (m.led >> 1)) :
                              (m.step < 2 * NCH) ? (m.led << 1) : 4'b0000;
               2'b01: r.led = (m.step < NCH) ? 4'(1 << m.step) : 4'b0000;
               2'b10: r.led = (m.step == 0) ? 4'b1111 : 4'b0000;
               default: r.led = (m.step == 0) ? 4'b0101 : 4'b1010;
            endcase
            if (m.step == len - 1) begin
               r.step  = 0;
               r.done  = 1'b1;
               r.cnt   = (m.cnt < 255) ? m.cnt + 1 : 255;
               r.modeq = md;
            end else begin
               r.step = m.step + 1;
            end
         end
      end else if (swd != 4'b0000) begin
         r.led = swd;
      end else begin
         r.bist = 1'b1; r.led = 4'b0000; r.step = 0; r.modeq = md; r.phase = 0;
      end
      return r;
   endfunction

   task automatic model_reset();
      ma = m_reset();
      mb = m_reset();
      swq.delete();
      ssq.delete();
      deb = 4'b0000;
   endtask

   task automatic model_edge_all();
      logic [3:0] ss;
      logic [3:0] use_sw;
      bit         same;
      ss = (swq.size() >= 2) ? swq[swq.size() - 2] : 4'b0000;
      use_sw = DEB ? deb : ss;
      ma = m_edge(ma, use_sw, mode_v, 10);
      mb = m_edge(mb, use_sw, mode_v, 1);
      ssq.push_back(ss);
      if (ssq.size() > DB) void'(ssq.pop_front());
      if (ssq.size() == DB) begin
         same = 1'b1;
         foreach (ssq[i]) if (ssq[i] != ss) same = 1'b0;
         if (same) deb = ss;
      end
      swq.push_back(sw_v);
      if (swq.size() > 4) void'(swq.pop_front());
   endtask

   task automatic set_in(input logic [3:0] s, input logic [1:0] m);
      sw_v = s; mode_v = m;
      ifa.sw = s; ifb.sw = s; ifa.mode = m; ifb.mode = m;
   endtask

   task automatic cmp_all();
      chk("a_led",  ifa.led,         ma.led);
      chk("a_bist", ifa.bist_active, ma.bist);
      chk("a_done", ifa.sweep_done,  ma.done);
      chk("a_cnt",  ifa.sweep_cnt,   ma.cnt);
      chk("b_led",  ifb.led,         mb.led);
      chk("b_bist", ifb.bist_active, mb.bist);
      chk("b_done", ifb.sweep_done,  mb.done);
      chk("b_cnt",  ifb.sweep_cnt,   mb.cnt);
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         model_edge_all();
         @(negedge clk);
         cmp_all();
      end
   endtask

   // Asynchronous reset between edges; outputs must settle without a clock edge.
   task automatic mid_reset();
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("rst_led",  ifa.led,         32'h0);
      chk("rst_cnt",  ifa.sweep_cnt,   32'h0);
      chk("rst_bist", ifa.bist_active, 32'h1);
      chk("rst_done", ifa.sweep_done,  32'h0);
      cmp_all();
      @(negedge clk);
      rst = 1'b0;
   endtask

   logic [3:0] fill_seq [9] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b1110,
                                4'b1100, 4'b1000, 4'b0000, 4'b0000};
   logic [3:0] t3_seq   [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000,
                                4'b1111, 4'b0000};

   initial begin
      set_in(4'b0000, 2'b00);
      model_reset();
      #12;
      chk("init_led",  ifa.led,         32'h0);
      chk("init_bist", ifa.bist_active, 32'h1);
      cmp_all();
      @(negedge clk);
      rst = 1'b0;

      // FILL sweep after reset
      for (int k = 0; k < 9; k++) begin
         cyc(10);
         chk("t1_fill", ifa.led, fill_seq[k]);
      end
      chk("t1_done", ifa.sweep_done, 32'h1);
      chk("t1_cnt",  ifa.sweep_cnt,  32'h1);

      // pass-through latency in and out
      set_in(4'b0101, 2'b00);
      cyc(LAT - 1);
      chk("t2_bist_early", ifa.bist_active, 32'h1);
      cyc(1);
      chk("t2_led_on",  ifa.led,         32'h5);
      chk("t2_bist_on", ifa.bist_active, 32'h0);
      set_in(4'b0000, 2'b00);
      cyc(LAT - 1);
      chk("t2_pass_hold", ifa.bist_active, 32'h0);
      cyc(1);
      chk("t2_led_off",  ifa.led,         32'h0);
      chk("t2_bist_off", ifa.bist_active, 32'h1);
      cyc(9);
      chk("t2_no_step", ifa.led, 32'h0);
      cyc(1);
      chk("t2_first", ifa.led, 32'h8);

      // WALK1 requested mid-FILL, BLINK requested mid-WALK1
      set_in(4'b0000, 2'b01);
      cyc(80);
      chk("t3_fill_end", ifa.sweep_done, 32'h1);
      chk("t3_cnt2",     ifa.sweep_cnt,  32'h2);
      for (int k = 0; k < 7; k++) begin
         cyc(10);
         chk("t3_seq", ifa.led, t3_seq[k]);
         if (k == 0) set_in(4'b0000, 2'b10);
      end
      chk("t3_cnt4", ifa.sweep_cnt, 32'h4);

      // saturation and tick/switch coincidence on the TICK_DIV=1 instance
      set_in(4'b0000, 2'b10);
      cyc(600);
      chk("t4_sat", ifb.sweep_cnt, 32'd255);
      set_in(4'b0011, 2'b10);
      cyc(LAT);
      chk("t4_led",  ifb.led,        32'h3);
      chk("t4_done", ifb.sweep_done, 32'h0);
      set_in(4'b0000, 2'b00);
      cyc(LAT + 1);

      // short switch pulse, then a held switch
      set_in(4'b0001, 2'b00);
      cyc(2);
      set_in(4'b0000, 2'b00);
      cyc(LAT + 6);
      if (DEB) chk("t6_glitch", ifa.bist_active, 32'h1);
      set_in(4'b0001, 2'b00);
      cyc(LAT - 1);
      chk("t6_hold_early", ifa.bist_active, 32'h1);
      cyc(1);
      chk("t6_hold_led", ifa.led, 32'h1);
      set_in(4'b0000, 2'b00);
      cyc(LAT + 1);

      // reset in the middle of a FILL sweep
      cyc(29);
      chk("t5_mid", ifa.led, 32'he);
      mid_reset();

      // randomised mode / switch activity
      for (int r = 0; r < 30; r++) begin
         if ($urandom_range(0, 1) == 0) set_in(4'b0000, 2'($urandom_range(0, 3)));
         else set_in(4'($urandom_range(1, 15)), 2'($urandom_range(0, 3)));
         cyc($urandom_range(1, 60));
         if ($urandom_range(0, 9) == 0) mid_reset();
      end
      set_in(4'b0000, 2'($urandom_range(0, 3)));
      cyc(200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
